i2c_target_bit_engine: RTL and testbench

Synthesizable I2C target (slave) front end that converts raw SCL/SDA pin activity into byte-level transfers, using the same width, read/write and shift-direction encoding as the I2C globals package. It sits directly downstream of the I2C bus interface, where the master BFM drives SCL/SDA. On write it hands received bytes to a register file. On read it pulls bytes from the register file through a valid/ready handshake. It detects START, repeated START and STOP, matches a 7-bit address, and generates the ACK bits.

---
 rtl/i2c_target_bit_engine.sv | 208 ++++++++++++++++++++
 tb/tb_i2c_target_bit_engine.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_target_bit_engine.sv
// I2C target front end: turns raw SCL/SDA pin activity into byte transfers with
// START/STOP detection, 7-bit address match and ACK generation.
module i2c_target_bit_engine #(
    parameter logic [6:0]  SLAVE_ADDRESS = 7'h68,
    parameter int unsigned DATA_WIDTH    = 8,
    parameter bit          MSB_FIRST     = 1'b1
) (
    input  logic                  pclk,
    input  logic                  areset,
    input  logic                  scl_i,
    input  logic                  sda_i,
    output logic                  sda_oe,
    output logic                  read_write,
    output logic                  addr_match,
    output logic                  busy,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic                  stop_det
);

    localparam int unsigned DW    = DATA_WIDTH;
    localparam int unsigned AW    = 7;
    localparam int unsigned CNT_W = 3;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DW - 1);

    typedef enum logic [2:0] {
        IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, IGNORE
    } state_t;

    state_t           state;
    logic             scl_s1, scl_s2, scl_d;
    logic             sda_s1, sda_s2, sda_d;
    logic             scl_rise_q, scl_fall_q, start_q, stop_q;
    logic [CNT_W-1:0] bit_cnt;
    logic [DW-1:0]    shift;
    logic [DW-1:0]    tx_shift;
    logic             ack_phase;

    logic [DW-1:0]    addr_shift_c;
    logic [DW-1:0]    rx_next_c;
    logic [DW-1:0]    tx_byte_c;
    logic [DW-1:0]    tx_shift_next_c;
    logic             tx_first_c;
    logic             tx_next_bit_c;

    // Pin synchronizers plus delayed copy; reset to the idle-bus level.
    always_ff @(posedge pclk or posedge areset) begin
        if (areset) begin
            scl_s1 <= 1'b1;
            scl_s2 <= 1'b1;
            scl_d  <= 1'b1;
            sda_s1 <= 1'b1;
            sda_s2 <= 1'b1;
            sda_d  <= 1'b1;
        end else begin
            scl_s1 <= scl_i;
            scl_s2 <= scl_s1;
            scl_d  <= scl_s2;
            sda_s1 <= sda_i;
            sda_s2 <= sda_s1;
            sda_d  <= sda_s2;
        end
    end

    // Registered bus events; sda_d is the SDA value aligned with them.
    always_ff @(posedge pclk or posedge areset) begin
        if (areset) begin
            scl_rise_q <= 1'b0;
            scl_fall_q <= 1'b0;
            start_q    <= 1'b0;
            stop_q     <= 1'b0;
        end else begin
            scl_rise_q <= scl_s2 & ~scl_d;
            scl_fall_q <= ~scl_s2 & scl_d;
            start_q    <= scl_s2 & scl_d & sda_d & ~sda_s2;
            stop_q     <= scl_s2 & scl_d & ~sda_d & sda_s2;
        end
    end

    assign addr_shift_c    = {shift[DW-2:0], sda_d};
    assign rx_next_c       = MSB_FIRST ? {shift[DW-2:0], sda_d} : {sda_d, shift[DW-1:1]};
    assign tx_byte_c       = tx_valid ? tx_data : '1;
    assign tx_first_c      = MSB_FIRST ? tx_byte_c[DW-1] : tx_byte_c[0];
    assign tx_shift_next_c = MSB_FIRST ? {tx_shift[DW-2:0], 1'b1} : {1'b1, tx_shift[DW-1:1]};
    assign tx_next_bit_c   = MSB_FIRST ? tx_shift[DW-2] : tx_shift[1];

    // Protocol FSM; START/STOP override any shifting in the same cycle.
    always_ff @(posedge pclk or posedge areset) begin
        if (areset) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            shift      <= '0;
            tx_shift   <= '1;
            ack_phase  <= 1'b0;
            sda_oe     <= 1'b0;
            read_write <= 1'b0;
            addr_match <= 1'b0;
            busy       <= 1'b0;
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            tx_ready   <= 1'b0;
            stop_det   <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            tx_ready <= 1'b0;
            stop_det <= 1'b0;
            if (stop_q) begin
                state      <= IDLE;
                busy       <= 1'b0;
                addr_match <= 1'b0;
                sda_oe     <= 1'b0;
                ack_phase  <= 1'b0;
                stop_det   <= 1'b1;
            end else if (start_q) begin
                state      <= ADDR;
                busy       <= 1'b1;
                addr_match <= 1'b0;
                sda_oe     <= 1'b0;
                ack_phase  <= 1'b0;
                bit_cnt    <= '0;
            end else begin
                case (state)
                    ADDR: if (scl_rise_q) begin
                        shift   <= addr_shift_c;
                        bit_cnt <= bit_cnt + CNT_W'(1);
                        if (bit_cnt == LAST_BIT) begin
                            read_write <= sda_d;
                            state      <= (shift[AW-1:0] == SLAVE_ADDRESS) ? ADDR_ACK : IGNORE;
                        end
                    end
                    ADDR_ACK: if (scl_fall_q) begin
                        if (!ack_phase) begin
                            sda_oe     <= 1'b1;
                            addr_match <= 1'b1;
                            ack_phase  <= 1'b1;
                        end else begin
                            ack_phase <= 1'b0;
                            bit_cnt   <= '0;
                            if (read_write) begin
                                tx_shift <= tx_byte_c;
                                sda_oe   <= ~tx_first_c;
                                tx_ready <= tx_valid;
                                state    <= RD_DATA;
                            end else begin
                                sda_oe <= 1'b0;
                                state  <= WR_DATA;
                            end
                        end
                    end
                    WR_DATA: if (scl_rise_q) begin
                        shift   <= rx_next_c;
                        bit_cnt <= bit_cnt + CNT_W'(1);
                        if (bit_cnt == LAST_BIT) begin
                            rx_data  <= rx_next_c;
                            rx_valid <= 1'b1;
                            state    <= WR_ACK;
                        end
                    end
                    WR_ACK: if (scl_fall_q) begin
                        if (!ack_phase) begin
                            sda_oe    <= 1'b1;
                            ack_phase <= 1'b1;
                        end else begin
                            sda_oe    <= 1'b0;
                            ack_phase <= 1'b0;
                            bit_cnt   <= '0;
                            state     <= WR_DATA;
                        end
                    end
                    RD_DATA: if (scl_rise_q) begin
                        bit_cnt <= bit_cnt + CNT_W'(1);
                        if (bit_cnt == LAST_BIT) begin
                            state <= RD_ACK;
                        end
                    end else if (scl_fall_q) begin
                        tx_shift <= tx_shift_next_c;
                        sda_oe   <= ~tx_next_bit_c;
                    end
                    // ack_phase marks a master ACK seen; the next fall starts a new byte.
                    RD_ACK: if (scl_fall_q) begin
                        if (!ack_phase) begin
                            sda_oe <= 1'b0;
                        end else begin
                            ack_phase <= 1'b0;
                            bit_cnt   <= '0;
                            tx_shift  <= tx_byte_c;
                            sda_oe    <= ~tx_first_c;
                            tx_ready  <= tx_valid;
                            state     <= RD_DATA;
                        end
                    end else if (scl_rise_q) begin
                        if (sda_d) begin
                            state <= IGNORE;
                        end else begin
                            ack_phase <= 1'b1;
                        end
                    end
                    IDLE, IGNORE: ;
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_target_bit_engine.sv
// Directed bench: bit-banged I2C master against an MSB-first target (0x68) and an
// LSB-first target (0x69) sharing one open-drain bus, with a receive scoreboard.
module tb_i2c_target_bit_engine;

    logic       pclk;
    logic       areset;
    logic       scl;
    logic       sda_m;
    logic       sda_bus;
    logic [7:0] tx_data_h, tx_data_l;
    logic       tx_valid_h, tx_valid_l;

    logic       oe_h, rw_h, am_h, busy_h, rxv_h, txr_h, stop_h;
    logic       oe_l, rw_l, am_l, busy_l, rxv_l, txr_l, stop_l;
    logic [7:0] rx_data_h, rx_data_l;

    int checks   = 0;
    int failures = 0;
    int oe_cnt   = 0;
    int stop_cnt_h = 0;
    int stop_cnt_l = 0;
    int txr_cnt  = 0;
    int busy_low_cnt = 0;

    logic [7:0] exp_rx_h[$];
    logic [7:0] exp_rx_l[$];
    logic [7:0] exp_rd[$];

    logic       ack;
    logic       oe_seen;
    logic [7:0] rb;
    int         base;

    assign sda_bus = sda_m & ~oe_h & ~oe_l;

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    i2c_target_bit_engine #(.SLAVE_ADDRESS(7'h68), .DATA_WIDTH(8), .MSB_FIRST(1'b1)) dut_h (
        .pclk(pclk), .areset(areset), .scl_i(scl), .sda_i(sda_bus),
        .sda_oe(oe_h), .read_write(rw_h), .addr_match(am_h), .busy(busy_h),
        .rx_data(rx_data_h), .rx_valid(rxv_h), .tx_data(tx_data_h), .tx_valid(tx_valid_h),
        .tx_ready(txr_h), .stop_det(stop_h)
    );

    i2c_target_bit_engine #(.SLAVE_ADDRESS(7'h69), .DATA_WIDTH(8), .MSB_FIRST(1'b0)) dut_l (
        .pclk(pclk), .areset(areset), .scl_i(scl), .sda_i(sda_bus),
        .sda_oe(oe_l), .read_write(rw_l), .addr_match(am_l), .busy(busy_l),
        .rx_data(rx_data_l), .rx_valid(rxv_l), .tx_data(tx_data_l), .tx_valid(tx_valid_l),
        .tx_ready(txr_l), .stop_det(stop_l)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Output monitor and receive scoreboard, sampled mid-cycle.
    always @(negedge pclk) begin
        if (oe_h | oe_l) oe_cnt++;
        if (stop_h) stop_cnt_h++;
        if (stop_l) stop_cnt_l++;
        if (txr_h) txr_cnt++;
        if (!busy_h) busy_low_cnt++;
        if (rxv_h) begin
            check("rx_h_pending", 32'(exp_rx_h.size() != 0), 32'd1);
            if (exp_rx_h.size() != 0) check("rx_h_data", 32'(rx_data_h), 32'(exp_rx_h.pop_front()));
        end
        if (rxv_l) begin
            check("rx_l_pending", 32'(exp_rx_l.size() != 0), 32'd1);
            if (exp_rx_l.size() != 0) check("rx_l_data", 32'(rx_data_l), 32'(exp_rx_l.pop_front()));
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic wclk(input int n);
        repeat (n) @(posedge pclk);
        #1;
    endtask

    task automatic i2c_start();
        if (scl == 1'b0) begin
            wclk(4); sda_m = 1'b1; wclk(4); scl = 1'b1; wclk(6);
        end
        sda_m = 1'b0; wclk(6); scl = 1'b0;
    endtask

    task automatic i2c_stop();
        wclk(4); sda_m = 1'b0; wclk(4); scl = 1'b1; wclk(6); sda_m = 1'b1; wclk(10);
    endtask

    task automatic send_bit(input logic b);
        wclk(4); sda_m = b; wclk(4); scl = 1'b1; wclk(8); scl = 1'b0;
    endtask

    task automatic write_byte(input logic [7:0] b, output logic a);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
        wclk(4); sda_m = 1'b1; wclk(4); scl = 1'b1; wclk(4); a = sda_bus; wclk(4); scl = 1'b0;
    endtask

    task automatic read_bits(output logic [7:0] b);
        wclk(2); sda_m = 1'b1;
        for (int i = 7; i >= 0; i--) begin
            if (i != 7) wclk(2);
            wclk(6); scl = 1'b1; wclk(4); b[i] = sda_bus; wclk(4); scl = 1'b0;
        end
    endtask

    task automatic master_ack(input logic a, output logic oe_at_ack);
        wclk(4); sda_m = a; wclk(4); scl = 1'b1; wclk(4); oe_at_ack = oe_h; wclk(4); scl = 1'b0;
    endtask

    initial begin
        scl = 1'b1; sda_m = 1'b1; areset = 1'b1;
        tx_data_h = 8'h00; tx_valid_h = 1'b0;
        tx_data_l = 8'h00; tx_valid_l = 1'b0;
        wclk(5);
        check("reset_outputs_h", 32'({oe_h, rw_h, am_h, busy_h, rx_data_h, rxv_h, txr_h, stop_h}), 32'd0);
        check("reset_outputs_l", 32'({oe_l, rw_l, am_l, busy_l, rx_data_l, rxv_l, txr_l, stop_l}), 32'd0);
        areset = 1'b0;
        wclk(5);

        // Write 0x68/W, 0xA5, STOP
        base = stop_cnt_h;
        exp_rx_h.push_back(8'hA5);
        i2c_start();
        check("t1_busy", 32'(busy_h), 32'd1);
        write_byte(8'hD0, ack);
        check("t1_addr_ack", 32'(ack), 32'd0);
        check("t1_addr_match", 32'(am_h), 32'd1);
        check("t1_read_write", 32'(rw_h), 32'd0);
        write_byte(8'hA5, ack);
        check("t1_data_ack", 32'(ack), 32'd0);
        i2c_stop();
        check("t1_stop_det", 32'(stop_cnt_h - base), 32'd1);
        check("t1_busy_after", 32'(busy_h), 32'd0);
        check("t1_match_after", 32'(am_h), 32'd0);
        check("t1_rx_drained", 32'(exp_rx_h.size()), 32'd0);

        // Foreign address 0x21/W, 0x55
        base = oe_cnt;
        i2c_start();
        write_byte(8'h42, ack);
        check("t2_addr_nack", 32'(ack), 32'd1);
        check("t2_addr_match", 32'(am_h), 32'd0);
        write_byte(8'h55, ack);
        check("t2_data_nack", 32'(ack), 32'd1);
        check("t2_oe_never", 32'(oe_cnt - base), 32'd0);
        base = stop_cnt_h;
        i2c_stop();
        check("t2_stop_det", 32'(stop_cnt_h - base), 32'd1);

        // Read 0x68/R, 0x3C, master NACK
        tx_data_h = 8'h3C; tx_valid_h = 1'b1;
        exp_rd.push_back(8'h3C);
        base = txr_cnt;
        i2c_start();
        write_byte(8'hD1, ack);
        check("t3_addr_ack", 32'(ack), 32'd0);
        check("t3_read_write", 32'(rw_h), 32'd1);
        read_bits(rb);
        check("t3_rd_byte", 32'(rb), 32'(exp_rd.pop_front()));
        check("t3_tx_ready_once", 32'(txr_cnt - base), 32'd1);
        master_ack(1'b1, oe_seen);
        check("t3_ack_released", 32'(oe_seen), 32'd0);
        base = oe_cnt;
        send_bit(1'b0);
        send_bit(1'b1);
        check("t3_ignore_quiet", 32'(oe_cnt - base), 32'd0);
        i2c_stop();
        check("t3_busy_after", 32'(busy_h), 32'd0);

        // Two-byte read, second byte without tx_valid
        tx_data_h = 8'h81; tx_valid_h = 1'b1;
        exp_rd.push_back(8'h81);
        exp_rd.push_back(8'hFF);
        base = txr_cnt;
        i2c_start();
        write_byte(8'hD1, ack);
        check("t4_addr_ack", 32'(ack), 32'd0);
        read_bits(rb);
        check("t4_rd_byte0", 32'(rb), 32'(exp_rd.pop_front()));
        tx_valid_h = 1'b0;
        master_ack(1'b0, oe_seen);
        check("t4_ack0_released", 32'(oe_seen), 32'd0);
        read_bits(rb);
        check("t4_rd_byte1", 32'(rb), 32'(exp_rd.pop_front()));
        master_ack(1'b1, oe_seen);
        i2c_stop();
        check("t4_tx_ready_once", 32'(txr_cnt - base), 32'd1);

        // Write 0x01, repeated START, read back-to-back in one busy period
        exp_rx_h.push_back(8'h01);
        tx_data_h = 8'h5A; tx_valid_h = 1'b1;
        exp_rd.push_back(8'h5A);
        i2c_start();
        base = busy_low_cnt;
        write_byte(8'hD0, ack);
        write_byte(8'h01, ack);
        check("t5_rx_data", 32'(rx_data_h), 32'h01);
        check("t5_rw_write", 32'(rw_h), 32'd0);
        i2c_start();
        check("t5_rs_match_clr", 32'(am_h), 32'd0);
        write_byte(8'hD1, ack);
        check("t5_rs_addr_ack", 32'(ack), 32'd0);
        check("t5_rw_read", 32'(rw_h), 32'd1);
        read_bits(rb);
        check("t5_rd_byte", 32'(rb), 32'(exp_rd.pop_front()));
        master_ack(1'b1, oe_seen);
        check("t5_busy_held", 32'(busy_low_cnt - base), 32'd0);
        i2c_stop();
        check("t5_busy_after", 32'(busy_h), 32'd0);
        tx_valid_h = 1'b0;

        // LSB-first target at 0x69
        exp_rx_l.push_back(8'hA5);
        exp_rx_l.push_back(8'h80);
        base = stop_cnt_l;
        i2c_start();
        write_byte(8'hD2, ack);
        check("t6_addr_ack", 32'(ack), 32'd0);
        check("t6_addr_match", 32'(am_l), 32'd1);
        write_byte(8'hA5, ack);
        check("t6_data0_ack", 32'(ack), 32'd0);
        write_byte(8'h01, ack);
        i2c_stop();
        check("t6_rx_data", 32'(rx_data_l), 32'h80);
        check("t6_rx_drained", 32'(exp_rx_l.size()), 32'd0);
        check("t6_stop_det", 32'(stop_cnt_l - base), 32'd1);

        // Reset in the middle of a read byte while SDA is pulled low
        tx_data_h = 8'h00; tx_valid_h = 1'b1;
        i2c_start();
        write_byte(8'hD1, ack);
        wclk(8); scl = 1'b1; wclk(2);
        check("t7_oe_before", 32'(oe_h), 32'd1);
        @(posedge pclk);
        #3 areset = 1'b1;
        #1;
        check("t7_oe_async", 32'(oe_h), 32'd0);
        check("t7_busy_async", 32'(busy_h), 32'd0);
        tx_valid_h = 1'b0;
        wclk(3);
        areset = 1'b0;
        wclk(3);
        check("t7_reset_outputs", 32'({oe_h, rw_h, am_h, busy_h, rx_data_h, rxv_h, txr_h, stop_h}), 32'd0);
        exp_rx_h.push_back(8'h77);
        i2c_start();
        write_byte(8'hD0, ack);
        check("t7_addr_ack", 32'(ack), 32'd0);
        write_byte(8'h77, ack);
        check("t7_data_ack", 32'(ack), 32'd0);
        i2c_stop();
        check("t7_rx_data", 32'(rx_data_h), 32'h77);
        check("t7_busy_after", 32'(busy_h), 32'd0);

        check("end_rx_h_drained", 32'(exp_rx_h.size()), 32'd0);
        check("end_rx_l_drained", 32'(exp_rx_l.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
